street_demand_detect: RTL and testbench
=======================================

STREET_DEMAND_DETECT -- requirements
Module: street_demand_detect

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 3: consecutive identical synchronized samples needed to accept a sensor level change (legal range 1..15).
REQ-002 Parameter WAIT_THRESH, default 1: queue depth at or above which waiting asserts (legal range 1..MAX_QUEUE).
REQ-003 Parameter MAX_QUEUE, default 15: saturation value of queue_cnt (legal range 1..15).
REQ-004 Parameter DEPART_CYC, default 2: green cycles per vehicle departure (legal range 1..15).
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 sensor_raw  input  1  vehicle loop detector; asynchronous to clk; may bounce.
REQ-009 ped_req  input  1  pedestrian push-button; synchronous to clk.
REQ-010 green  input  1  green light of this street, from the street light controller.
REQ-011 waiting  output  1  registered demand flag, driven into the street light controller.
REQ-012 queue_cnt  output  4  registered estimate of vehicles queued.
REQ-013 overflow  output  1  sticky flag: an arrival occurred while queue_cnt == MAX_QUEUE.

Function
REQ-014 sensor_raw SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-015 Debounce FSM states: LOW_STABLE, CHK_HIGH, HIGH_STABLE, CHK_LOW.
REQ-016 LOW_STABLE SHALL go to CHK_HIGH when the synchronized sample is 1 and clear the debounce counter.
REQ-017 CHK_HIGH SHALL count consecutive 1 samples and go to HIGH_STABLE when the count reaches DEBOUNCE_CYC.
REQ-018 CHK_HIGH SHALL return to LOW_STABLE on any 0 sample.
REQ-019 HIGH_STABLE, CHK_LOW and LOW_STABLE SHALL mirror REQ-016 to REQ-018 with the polarity inverted.
REQ-020 The CHK_HIGH to HIGH_STABLE transition SHALL generate a one-cycle arrival pulse; no other transition generates one.
REQ-021 Latency: sensor_raw held high from setup before edge N SHALL increment queue_cnt at edge N+2+DEBOUNCE_CYC.
REQ-022 Departure timer SHALL run only while green == 1.
  - counts 1..DEPART_CYC
  - at DEPART_CYC it produces a departure pulse and reloads 1
  - it SHALL reset to 0 in the cycle green == 0
REQ-023 A departure with queue_cnt == 0 SHALL be ignored; queue_cnt never underflows.
REQ-024 An arrival with queue_cnt == MAX_QUEUE SHALL leave queue_cnt unchanged and set overflow.
REQ-025 Simultaneous arrival and departure SHALL leave queue_cnt unchanged, including at 0 and at MAX_QUEUE; overflow is not set.
REQ-026 ped_pend SHALL set on a ped_req rising edge (registered compare) while green == 0.
REQ-027 ped_pend SHALL clear on the first cycle green == 1; set and clear in the same cycle resolves to clear.
REQ-028 waiting SHALL be registered: waiting <= (next queue_cnt >= WAIT_THRESH) | next ped_pend, so it updates on the same edge as queue_cnt.
REQ-029 overflow SHALL clear only on reset.

Reset
REQ-030 On rst_n low, asynchronously and immediately:
  - synchronizer flops = 0
  - debounce FSM = LOW_STABLE
  - debounce counter = 0
  - departure timer = 0
  - queue_cnt = 0
  - ped_pend = 0
  - waiting = 0
  - overflow = 0
REQ-031 Reset mid-debounce or mid-departure SHALL discard the partial count; no pulse is generated on release.
REQ-032 The first sample after rst_n deasserts SHALL be treated as a fresh sample from LOW_STABLE.

Structure
REQ-033 A shared traffic package SHALL hold the debounce FSM state encoding (one-hot, 4 bits) and the queue width constant (4).
REQ-034 The debounce path (synchronizer plus FSM) SHALL be one sub-module, sensor_debounce, outputting the arrival pulse.
  - queue, departure and ped logic stay in the top module.
REQ-035 Formal assertions guarded by FORMAL:
  - queue_cnt <= MAX_QUEUE
  - waiting == (queue_cnt >= WAIT_THRESH | ped_pend)
  - debounce FSM state is one-hot

Verification
REQ-036 Raw 0->1 held 10 cycles with green=0 -> queue_cnt 0->1 exactly 5 edges after the first high sample; waiting=1 on the same edge.
REQ-037 Raw 1-cycle glitches every 2 cycles for 20 cycles -> queue_cnt stays 0; no arrival pulse.
REQ-038 Queue preloaded to 3, green=1 held 6 cycles, no arrivals -> queue_cnt 3->2->1->0 at cycles 2, 4, 6; waiting drops at cycle 6.
REQ-039 16 clean arrivals with green=0 -> queue_cnt saturates at 15; overflow=1 after the 16th arrival and stays 1 until reset.
REQ-040 Queue=4, arrival pulse coincides with a departure pulse -> queue_cnt stays 4; overflow stays 0.
REQ-041 ped_req pulse with queue_cnt=0, green=0 -> waiting=1 next edge; green=1 for 1 cycle -> waiting=0; rst_n pulsed low mid-CHK_HIGH -> all outputs 0 immediately.

Source files
------------

// File: rtl/street_demand_detect_pkg.sv
// rtl/street_demand_detect_pkg.sv - shared traffic types: debounce state encoding and queue width
package street_demand_detect_pkg;

    localparam int QUEUE_W   = 4;
    localparam int DEB_CNT_W = 4;

    typedef enum logic [3:0] {
        LOW_STABLE  = 4'b0001,
        CHK_HIGH    = 4'b0010,
        HIGH_STABLE = 4'b0100,
        CHK_LOW     = 4'b1000
    } deb_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - loop detector synchronizer and debounce FSM, emits one arrival pulse per accepted rising level
module sensor_debounce
    import street_demand_detect_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_raw,
    output logic arrival
);

    localparam logic [DEB_CNT_W-1:0] DEB_LIMIT = DEB_CNT_W'(DEBOUNCE_CYC);
    localparam logic [DEB_CNT_W-1:0] CNT_ONE   = DEB_CNT_W'(1);

    logic                 sync_q1;
    logic                 sync_q2;
    deb_state_t           state;
    logic [DEB_CNT_W-1:0] cnt;
    logic [DEB_CNT_W-1:0] cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sensor_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign cnt_inc = cnt + CNT_ONE;

    // Combinational so the queue can count the arrival on the very edge the FSM accepts it.
    assign arrival = (state == CHK_HIGH) && sync_q2 && (cnt_inc == DEB_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOW_STABLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                LOW_STABLE: begin
                    if (sync_q2) begin
                        state <= CHK_HIGH;
                        cnt   <= '0;
                    end
                end
                CHK_HIGH: begin
                    if (!sync_q2)
                        state <= LOW_STABLE;
                    else if (cnt_inc == DEB_LIMIT)
                        state <= HIGH_STABLE;
                    else
                        cnt <= cnt_inc;
                end
                HIGH_STABLE: begin
                    if (!sync_q2) begin
                        state <= CHK_LOW;
                        cnt   <= '0;
                    end
                end
                CHK_LOW: begin
                    if (sync_q2)
                        state <= HIGH_STABLE;
                    else if (cnt_inc == DEB_LIMIT)
                        state <= LOW_STABLE;
                    else
                        cnt <= cnt_inc;
                end
                default: begin
                    state <= LOW_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef FORMAL
    always_comb assert ($onehot(state));
`endif

endmodule

// File: rtl/street_demand_detect.sv
// rtl/street_demand_detect.sv - per-street vehicle queue estimate, pedestrian latch and demand flag
module street_demand_detect
    import street_demand_detect_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 3,
    parameter int WAIT_THRESH  = 1,
    parameter int MAX_QUEUE    = 15,
    parameter int DEPART_CYC   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sensor_raw,
    input  logic               ped_req,
    input  logic               green,
    output logic               waiting,
    output logic [QUEUE_W-1:0] queue_cnt,
    output logic               overflow
);

    localparam logic [QUEUE_W-1:0] MAX_Q     = QUEUE_W'(MAX_QUEUE);
    localparam logic [QUEUE_W-1:0] WAIT_LIM  = QUEUE_W'(WAIT_THRESH);
    localparam logic [QUEUE_W-1:0] DEP_LIMIT = QUEUE_W'(DEPART_CYC);
    localparam logic [QUEUE_W-1:0] ONE       = QUEUE_W'(1);

    logic               arrival;
    logic               departure;
    logic [QUEUE_W-1:0] dep_timer;
    logic [QUEUE_W-1:0] dep_next;
    logic [QUEUE_W-1:0] q_next;
    logic               ovf_set;
    logic               ped_req_q;
    logic               ped_pend;
    logic               ped_next;

    sensor_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_raw (sensor_raw),
        .arrival    (arrival)
    );

    always_comb begin
        dep_next  = (dep_timer >= DEP_LIMIT) ? ONE : dep_timer + ONE;
        departure = green && (dep_next == DEP_LIMIT);
    end

    // An arrival cancelling a departure leaves the count alone, even at the 0 and MAX_Q rails.
    always_comb begin
        q_next  = queue_cnt;
        ovf_set = 1'b0;
        if (arrival && !departure) begin
            if (queue_cnt == MAX_Q)
                ovf_set = 1'b1;
            else
                q_next = queue_cnt + ONE;
        end else if (departure && !arrival && queue_cnt != '0) begin
            q_next = queue_cnt - ONE;
        end
    end

    always_comb begin
        ped_next = 1'b0;
        if (!green)
            ped_next = ped_pend | (ped_req & ~ped_req_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dep_timer <= '0;
            queue_cnt <= '0;
            overflow  <= 1'b0;
            ped_req_q <= 1'b0;
            ped_pend  <= 1'b0;
            waiting   <= 1'b0;
        end else begin
            dep_timer <= green ? dep_next : '0;
            queue_cnt <= q_next;
            overflow  <= overflow | ovf_set;
            ped_req_q <= ped_req;
            ped_pend  <= ped_next;
            waiting   <= (q_next >= WAIT_LIM) | ped_next;
        end
    end

`ifdef FORMAL
    always_comb begin
        assert (queue_cnt <= MAX_Q);
        assert (waiting == ((queue_cnt >= WAIT_LIM) | ped_pend));
    end
`endif

endmodule

// File: tb/tb_street_demand_detect.sv
// tb/tb_street_demand_detect.sv - vector table, corner sequences and random run against a run-length reference model
module tb_street_demand_detect;

    localparam int DEB  = 3;
    localparam int WT   = 1;
    localparam int MAXQ = 15;
    localparam int DEP  = 2;

    logic       clk;
    logic       rst_n;
    logic       raw;
    logic       ped;
    logic       grn;
    logic       waiting;
    logic [3:0] queue_cnt;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    street_demand_detect #(
        .DEBOUNCE_CYC (DEB),
        .WAIT_THRESH  (WT),
        .MAX_QUEUE    (MAXQ),
        .DEPART_CYC   (DEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_raw (raw),
        .ped_req    (ped),
        .green      (grn),
        .waiting    (waiting),
        .queue_cnt  (queue_cnt),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic raw;
        logic ped;
        logic grn;
        int   ncyc;
        int   q;
        logic w;
        logic o;
    } vec_t;

    vec_t tbl[11];

    // Reference model: sensor acceptance as a run length of samples differing from the accepted level.
    logic m_hist[$];
    logic m_level;
    int   m_run;
    int   m_green_run;
    int   m_q;
    logic m_ovf;
    logic m_pend;
    logic m_pprev;
    bit   model_on = 0;

    task automatic model_reset();
        m_hist.delete();
        m_hist.push_back(1'b0);
        m_hist.push_back(1'b0);
        m_level     = 1'b0;
        m_run       = 0;
        m_green_run = 0;
        m_q         = 0;
        m_ovf       = 1'b0;
        m_pend      = 1'b0;
        m_pprev     = 1'b0;
    endtask

    task automatic model_step();
        logic samp;
        bit   arr;
        bit   dep;
        samp = m_hist.pop_front();
        m_hist.push_back(raw);
        arr = 0;
        if (samp != m_level) begin
            m_run++;
            if (m_run == DEB + 1) begin
                m_level = samp;
                m_run   = 0;
                arr     = samp;
            end
        end else begin
            m_run = 0;
        end
        m_green_run = grn ? m_green_run + 1 : 0;
        dep = grn && (m_green_run % DEP == 0);
        if (arr && !dep) begin
            if (m_q == MAXQ) m_ovf = 1'b1;
            else m_q++;
        end else if (dep && !arr && m_q > 0) begin
            m_q--;
        end
        if (grn) m_pend = 1'b0;
        else if (ped && !m_pprev) m_pend = 1'b1;
        m_pprev = ped;
    endtask

    task automatic tick();
        @(posedge clk);
        if (model_on) model_step();
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        model_on = 0;
        raw = 1'b0;
        ped = 1'b0;
        grn = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic arrive();
        raw = 1'b1;
        repeat (6) tick();
        raw = 1'b0;
        repeat (6) tick();
    endtask

    // Arrival accepted on the sixth raw-high edge, second green edge produces a departure on the same edge.
    task automatic coincide(input int exp_q, input logic exp_o, input string name);
        for (int i = 0; i < 6; i++) begin
            raw = 1'b1;
            grn = (i >= 4);
            tick();
        end
        chk({name, "_q"}, queue_cnt, exp_q);
        chk({name, "_ovf"}, overflow, exp_o);
        raw = 1'b0;
        grn = 1'b0;
        repeat (6) tick();
        chk({name, "_q_after"}, queue_cnt, exp_q);
    endtask

    int exp_q38[6] = '{3, 2, 2, 1, 1, 0};
    int exp_w38[6] = '{1, 1, 1, 1, 1, 0};

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 3,  0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 5,  0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1,  1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 10, 1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1,  1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1,  0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1,  0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2,  0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1,  0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1,  0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1,  0, 1'b0, 1'b0};

        do_reset();
        chk("reset_q", queue_cnt, 0);
        chk("reset_wait", waiting, 0);
        chk("reset_ovf", overflow, 0);

        for (int r = 0; r < 11; r++) begin
            raw = tbl[r].raw;
            ped = tbl[r].ped;
            grn = tbl[r].grn;
            repeat (tbl[r].ncyc) tick();
            chk($sformatf("vec%0d_q", r), queue_cnt, tbl[r].q);
            chk($sformatf("vec%0d_wait", r), waiting, tbl[r].w);
            chk($sformatf("vec%0d_ovf", r), overflow, tbl[r].o);
        end

        do_reset();
        for (int i = 0; i < 20; i++) begin
            raw = (i % 2 == 0);
            tick();
            chk("glitch_q", queue_cnt, 0);
            chk("glitch_arrival", dut.u_deb.arrival, 0);
        end
        raw = 1'b0;
        repeat (4) tick();

        do_reset();
        repeat (3) arrive();
        chk("preload_q", queue_cnt, 3);
        grn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("drain%0d_q", i + 1), queue_cnt, exp_q38[i]);
            chk($sformatf("drain%0d_wait", i + 1), waiting, exp_w38[i]);
        end
        grn = 1'b0;
        tick();

        do_reset();
        coincide(0, 1'b0, "coin_zero");
        repeat (4) arrive();
        coincide(4, 1'b0, "coin_four");
        repeat (11) arrive();
        chk("sat15_q", queue_cnt, 15);
        chk("sat15_ovf", overflow, 0);
        coincide(15, 1'b0, "coin_max");
        arrive();
        chk("sat16_q", queue_cnt, 15);
        chk("sat16_ovf", overflow, 1);
        grn = 1'b1;
        tick();
        tick();
        grn = 1'b0;
        tick();
        chk("sat_drain_q", queue_cnt, 14);
        chk("sat_drain_ovf", overflow, 1);
        arrive();
        chk("sat_refill_q", queue_cnt, 15);
        chk("sat_sticky_ovf", overflow, 1);

        do_reset();
        repeat (2) arrive();
        raw = 1'b1;
        repeat (3) tick();
        chk("pre_rst_q", queue_cnt, 2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_q", queue_cnt, 0);
        chk("async_rst_wait", waiting, 0);
        chk("async_rst_ovf", overflow, 0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("fresh_q_edge5", queue_cnt, 0);
        tick();
        chk("fresh_q_edge6", queue_cnt, 1);
        chk("fresh_wait_edge6", waiting, 1);

        do_reset();
        model_on = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) raw = ~raw;
            if ($urandom_range(0, 11) == 0) grn = ~grn;
            ped = ($urandom_range(0, 7) == 0);
            tick();
            chk("rnd_q", queue_cnt, m_q);
            chk("rnd_wait", waiting, (m_q >= WT) || m_pend);
            chk("rnd_ovf", overflow, m_ovf);
        end
        model_on = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
